dmem_responder: RTL and testbench

- Handshaked data-memory responder: the target end of the pipeline's MEM-stage load/store interface.
- Accepts one word-addressed read or write request at a time and applies byte enables.
- Returns a response after a programmable number of wait states.
- Lets the pipelined CPU be verified against a slow memory rather than a zero-latency array.

---
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked word-addressed data memory with programmable wait states.
// Define DMEM_RSP_WRITE_READBACK_EN to return the post-merge word on store responses.
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int WAIT_CYC = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    req_t        lat;
    logic [31:0] mem [DEPTH];

    logic              in_idle;
    logic              accept;
    logic              commit;
    req_t              cur;
    logic              c_err;
    logic [ADDR_W-1:0] c_idx;
    logic [31:0]       c_word;
    logic [31:0]       c_merged;
    logic [31:0]       c_rdata;

    assign in_idle   = (state == IDLE);
    assign req_ready = in_idle;
    assign busy      = !in_idle;
    assign accept    = req_valid && in_idle;

    // With zero wait states the commit uses the live request on the accept edge.
    assign commit = in_idle ? (accept && (WAIT_CYC == 0))
                            : ((state == WAIT) && (cnt == 4'd1));

    always_comb begin
        cur = lat;
        if (in_idle) begin
            cur.we    = req_we;
            cur.addr  = req_addr;
            cur.wdata = req_wdata;
            cur.be    = req_be;
        end
    end

    assign c_err = (cur.addr[1:0] != 2'b00) ||
                   ((cur.addr >> (ADDR_W + 2)) != 32'd0);
    assign c_idx  = cur.addr[ADDR_W+1:2];
    assign c_word = mem[c_idx];

    always_comb begin
        c_merged = c_word;
        for (int i = 0; i < 4; i++) begin
            if (cur.be[i]) begin
                c_merged[8*i +: 8] = cur.wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        c_rdata = 32'd0;
        if (!c_err) begin
            if (!cur.we) begin
                c_rdata = c_word;
            end else begin
`ifdef DMEM_RSP_WRITE_READBACK_EN
                c_rdata = c_merged;
`else
                c_rdata = 32'd0;
`endif
            end
        end
    end

    // Memory lives in the reset block so a store can never commit while Clrn is low.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (commit) begin
                rsp_valid <= 1'b1;
                rsp_err   <= c_err;
                rsp_rdata <= c_rdata;
                if (cur.we && !c_err) begin
                    mem[c_idx] <= c_merged;
                end
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat.we    <= req_we;
                        lat.addr  <= req_addr;
                        lat.wdata <= req_wdata;
                        lat.be    <= req_be;
                        cnt       <= WAIT_INIT;
                        state     <= (WAIT_CYC == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized + directed bench against an associative-array memory model.
// Instance 0 runs with two wait states, instance 1 with zero wait states.
module tb_dmem_responder;

    localparam int AW = 10;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic clk = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    logic        rq_v [2];
    logic        rq_r [2];
    logic        rq_we[2];
    logic [31:0] rq_a [2];
    logic [31:0] rq_wd[2];
    logic [3:0]  rq_be[2];
    logic        rs_v [2];
    logic        rs_r [2];
    logic [31:0] rs_d [2];
    logic        rs_e [2];
    logic        bsy  [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit [31:0] ref_mem [int];

    dmem_responder #(.ADDR_W(AW), .WAIT_CYC(W0)) u_slow (
        .Clk(clk), .Clrn(clrn),
        .req_valid(rq_v[0]), .req_ready(rq_r[0]), .req_we(rq_we[0]),
        .req_addr(rq_a[0]), .req_wdata(rq_wd[0]), .req_be(rq_be[0]),
        .rsp_valid(rs_v[0]), .rsp_ready(rs_r[0]), .rsp_rdata(rs_d[0]),
        .rsp_err(rs_e[0]), .busy(bsy[0])
    );

    dmem_responder #(.ADDR_W(AW), .WAIT_CYC(W1)) u_fast (
        .Clk(clk), .Clrn(clrn),
        .req_valid(rq_v[1]), .req_ready(rq_r[1]), .req_we(rq_we[1]),
        .req_addr(rq_a[1]), .req_wdata(rq_wd[1]), .req_be(rq_be[1]),
        .rsp_valid(rs_v[1]), .rsp_ready(rs_r[1]), .rsp_rdata(rs_d[1]),
        .rsp_err(rs_e[1]), .busy(bsy[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference memory: one word per key, bytes merged by plain masking.
    function automatic void model(input int d, input bit we,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [3:0] be,
                                  output logic [31:0] rd, output bit err);
        int          key;
        logic [31:0] word;
        err = (addr % 4 != 0) || (addr >= 32'(4 << AW));
        rd  = 32'd0;
        if (err) return;
        key  = d * (1 << AW) + int'(addr / 4);
        word = ref_mem.exists(key) ? ref_mem[key] : 32'd0;
        if (!we) begin
            rd = word;
        end else begin
            for (int i = 0; i < 4; i++)
                if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
            ref_mem[key] = word;
`ifdef DMEM_RSP_WRITE_READBACK_EN
            rd = word;
`endif
        end
    endfunction

    task automatic xact(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int hold);
        int          cyc;
        logic [31:0] exp_d;
        bit          exp_e;
        model(d, we, addr, wd, be, exp_d, exp_e);
        check("req_ready_idle", rq_r[d], 1);
        rq_v[d]  = 1'b1;
        rq_we[d] = we;
        rq_a[d]  = addr;
        rq_wd[d] = wd;
        rq_be[d] = be;
        rs_r[d]  = 1'b0;
        @(posedge clk); #1;
        rq_v[d]  = 1'b0;
        rq_we[d] = 1'($urandom);
        rq_a[d]  = $urandom;
        rq_wd[d] = $urandom;
        rq_be[d] = 4'($urandom);
        cyc = 1;
        while (!rs_v[d] && cyc < 40) begin
            check("busy_wait", bsy[d], 1);
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, wait_of(d) + 1);
        check("rsp_err", rs_e[d], exp_e);
        check("rsp_rdata", rs_d[d], exp_d);
        for (int i = 0; i < hold; i++) begin
            rq_v[d] = 1'b1;
            @(posedge clk); #1;
            check("hold_valid", rs_v[d], 1);
            check("hold_rdata", rs_d[d], exp_d);
            check("hold_err", rs_e[d], exp_e);
            check("hold_req_ready", rq_r[d], 0);
        end
        check("resp_req_ready", rq_r[d], 0);
        rq_v[d] = 1'b0;
        rs_r[d] = 1'b1;
        @(posedge clk); #1;
        rs_r[d] = 1'b0;
        check("post_valid", rs_v[d], 0);
        check("post_err", rs_e[d], 0);
        check("post_rdata_kept", rs_d[d], exp_d);
        check("post_req_ready", rq_r[d], 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        logic [31:0] ed;
        logic [31:0] a;
        bit          ee;
        bit          seen;
        int          acc;
        int          rsp;
        int          sel;

        for (int d = 0; d < 2; d++) begin
            rq_v[d] = 1'b0; rq_we[d] = 1'b0; rq_a[d] = 32'd0;
            rq_wd[d] = 32'd0; rq_be[d] = 4'd0; rs_r[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", rq_r[d], 1);
            check("rst_busy", bsy[d], 0);
            check("rst_rsp_valid", rs_v[d], 0);
            check("rst_rsp_rdata", rs_d[d], 32'd0);
            check("rst_rsp_err", rs_e[d], 0);
        end
        clrn = 1'b1;
        @(posedge clk); #1;

        xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0);
        check("load_full", rs_d[0], 32'hDEADBEEF);
        xact(0, 1, 32'h10, 32'h00000012, 4'h1, 0);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0);
        check("load_merged", rs_d[0], 32'hDEADBE12);
        xact(0, 0, 32'h13, 32'h0, 4'h0, 0);
        xact(0, 0, 32'h1000, 32'h0, 4'h0, 0);
        xact(0, 1, 32'h11, 32'hFFFFFFFF, 4'hF, 0);
        xact(0, 1, 32'h1010, 32'hFFFFFFFF, 4'hF, 0);
        xact(0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 5);
        check("load_unchanged", rs_d[0], 32'hDEADBE12);

        for (int w = 0; w < 16; w++)
            xact(0, 1, 32'(4 * w), $urandom, 4'hF, 0);
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            a   = 32'(4 * $urandom_range(0, 15));
            if (sel == 0) a = a + 32'($urandom_range(1, 3));
            else if (sel == 1) a = $urandom | 32'h1000;
            xact(0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
                 $urandom_range(0, 2));
        end

        xact(0, 1, 32'h20, 32'h11111111, 4'hF, 0);
        rq_v[0] = 1'b1; rq_we[0] = 1'b1; rq_a[0] = 32'h20;
        rq_wd[0] = 32'h22222222; rq_be[0] = 4'hF;
        @(posedge clk); #1;
        rq_v[0] = 1'b0;
        check("abort_busy", bsy[0], 1);
        #2 clrn = 1'b0;
        #1;
        check("abort_rsp_valid", rs_v[0], 0);
        check("abort_req_ready", rq_r[0], 1);
        check("abort_rsp_rdata", rs_d[0], 32'd0);
        @(posedge clk);
        #3 clrn = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rs_v[0]) seen = 1'b1;
        end
        check("abort_no_rsp", seen, 0);
        check("abort_ready_after", rq_r[0], 1);
        xact(0, 0, 32'h20, 32'h0, 4'h0, 0);
        check("abort_old_data", rs_d[0], 32'h11111111);

        for (int w = 0; w < 4; w++)
            xact(1, 1, 32'(4 * w), $urandom, 4'hF, 0);
        acc = 0;
        rsp = 0;
        rq_v[1] = 1'b1; rq_we[1] = 1'b0; rq_be[1] = 4'hF;
        rs_r[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rq_a[1] = 32'(4 * $urandom_range(0, 3));
            check("tp_req_ready", rq_r[1], (i % 2) == 0);
            check("tp_rsp_valid", rs_v[1], (i % 2) == 1);
            if (rq_r[1]) begin
                model(1, 1'b0, rq_a[1], 32'd0, 4'hF, ed, ee);
                q.push_back(ed);
                acc++;
            end
            if (rs_v[1]) begin
                rsp++;
                if (q.size() > 0) check("tp_rdata", rs_d[1], q.pop_front());
                else check("tp_orphan_rsp", q.size(), 1);
            end
            @(posedge clk); #1;
        end
        rq_v[1] = 1'b0;
        rs_r[1] = 1'b0;
        check("tp_accepts", acc, 10);
        check("tp_responses", rsp, 10);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
